// File: rtl/associative_memory_multi_pkg.sv
// associative_memory_multi_pkg
// Shared definitions for the multi-channel associative memory:
//   - default sizing constants (hypervector width, classes, channels,
//     modalities, popcount chunk width)
//   - the controller state encoding (IDLE=0, COMPUTE=1, OUTPUT=2)
//   - ceilLog2 / fieldWidth helpers used to size labels, distances and
//     counters
// No ports; imported by the interface, the top and the popcount sub-module.
package associative_memory_multi_pkg;

    localparam int DEFAULT_HV_DIMENSION = 2000;
    localparam int DEFAULT_CLASSES      = 5;
    localparam int DEFAULT_CHANNELS     = 2;
    localparam int DEFAULT_MODALITIES   = 3;
    localparam int DEFAULT_AM_CHUNK     = 250;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } amState_e;

    // Smallest w with 2**w >= value (0 for value <= 1).
    function automatic int ceilLog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Width of a field that must exist even when it only ever holds zero.
    function automatic int fieldWidth(input int value);
        int w;
        w = ceilLog2(value);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/associative_memory_multi_if.sv
// associative_memory_multi_if
// Bundles the query handshake, the result handshake and the prototype write
// port of the associative memory.
//   slave  modport : the memory itself (consumes queries and writes, produces
//                    results and ready flags)
//   master modport : the upstream/downstream environment
// Signals:
//   ValidIn_SI / ReadyOut_SO       query handshake
//   HypervectorIn_DI               MODALITIES packed vectors, modality m in slice m
//   ValidOut_SO / ReadyIn_SI       result handshake
//   LabelOut_DO / DistanceOut_DO   per-channel result, channel ch in slice ch
//   AmWrEn_SI / AmWrReady_SO       prototype write handshake
//   AmWrChannel_DI / AmWrClass_DI / AmWrData_DI   write target and data
interface associative_memory_multi_if
    import associative_memory_multi_pkg::*;
#(
    parameter int HV_DIMENSION = DEFAULT_HV_DIMENSION,
    parameter int CLASSES      = DEFAULT_CLASSES,
    parameter int CHANNELS     = DEFAULT_CHANNELS,
    parameter int MODALITIES   = DEFAULT_MODALITIES
) ();

    localparam int LABEL_WIDTH    = fieldWidth(CLASSES);
    localparam int DISTANCE_WIDTH = ceilLog2(HV_DIMENSION + 1);
    localparam int CHANNEL_WIDTH  = fieldWidth(CHANNELS);

    logic                                  ValidIn_SI;
    logic                                  ReadyOut_SO;
    logic [0:MODALITIES*HV_DIMENSION-1]    HypervectorIn_DI;
    logic                                  ValidOut_SO;
    logic                                  ReadyIn_SI;
    logic [CHANNELS*LABEL_WIDTH-1:0]       LabelOut_DO;
    logic [CHANNELS*DISTANCE_WIDTH-1:0]    DistanceOut_DO;
    logic                                  AmWrEn_SI;
    logic                                  AmWrReady_SO;
    logic [CHANNEL_WIDTH-1:0]              AmWrChannel_DI;
    logic [LABEL_WIDTH-1:0]                AmWrClass_DI;
    logic [0:HV_DIMENSION-1]               AmWrData_DI;

    modport slave (
        input  ValidIn_SI, HypervectorIn_DI, ReadyIn_SI,
        input  AmWrEn_SI, AmWrChannel_DI, AmWrClass_DI, AmWrData_DI,
        output ReadyOut_SO, ValidOut_SO, LabelOut_DO, DistanceOut_DO, AmWrReady_SO
    );

    modport master (
        output ValidIn_SI, HypervectorIn_DI, ReadyIn_SI,
        output AmWrEn_SI, AmWrChannel_DI, AmWrClass_DI, AmWrData_DI,
        input  ReadyOut_SO, ValidOut_SO, LabelOut_DO, DistanceOut_DO, AmWrReady_SO
    );

endinterface

// File: rtl/associative_memory_multi_popcount.sv
// hv_chunk_popcount
// Purely combinational population count of one CHUNK_WIDTH slice.
// Ports:
//   Chunk_DI  in   CHUNK_WIDTH                 bits to count
//   Count_DO  out  ceilLog2(CHUNK_WIDTH+1)     number of ones
module hv_chunk_popcount
    import associative_memory_multi_pkg::*;
#(
    parameter int CHUNK_WIDTH = DEFAULT_AM_CHUNK,
    parameter int POP_WIDTH   = ceilLog2(CHUNK_WIDTH + 1)
) (
    input  logic [CHUNK_WIDTH-1:0] Chunk_DI,
    output logic [POP_WIDTH-1:0]   Count_DO
);

    // Straight adder chain; synthesis rebalances it into a tree.
    always_comb begin
        Count_DO = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            Count_DO = Count_DO + POP_WIDTH'(Chunk_DI[i]);
        end
    end

endmodule

// File: rtl/associative_memory_multi.sv
// associative_memory_multi
// Majority-bundles MODALITIES hypervectors into a query, then searches CHANNELS
// independent prototype banks in parallel, one CHUNK_WIDTH slice per cycle,
// reporting the nearest class and its Hamming distance per channel.
// Ports:
//   Clk_CI    clock
//   Reset_RI  synchronous active-high reset
//   amIf      slave side of associative_memory_multi_if (query, result and
//             prototype write handshakes)
module associative_memory_multi
    import associative_memory_multi_pkg::*;
#(
    parameter int HV_DIMENSION = DEFAULT_HV_DIMENSION,
    parameter int CLASSES      = DEFAULT_CLASSES,
    parameter int CHANNELS     = DEFAULT_CHANNELS,
    parameter int MODALITIES   = DEFAULT_MODALITIES,
    parameter int CHUNK_WIDTH  = DEFAULT_AM_CHUNK
) (
    input  logic                      Clk_CI,
    input  logic                      Reset_RI,
    associative_memory_multi_if.slave amIf
);

    localparam int NUM_CHUNKS      = HV_DIMENSION / CHUNK_WIDTH;
    localparam int LABEL_WIDTH     = fieldWidth(CLASSES);
    localparam int DISTANCE_WIDTH  = ceilLog2(HV_DIMENSION + 1);
    localparam int CHUNK_CNT_WIDTH = fieldWidth(NUM_CHUNKS);
    localparam int POP_WIDTH       = ceilLog2(CHUNK_WIDTH + 1);
    localparam logic [LABEL_WIDTH-1:0]     LAST_CLASS = LABEL_WIDTH'(CLASSES - 1);
    localparam logic [CHUNK_CNT_WIDTH-1:0] LAST_CHUNK = CHUNK_CNT_WIDTH'(NUM_CHUNKS - 1);

    amState_e                    state;
    logic [0:HV_DIMENSION-1]     protoMem [CHANNELS][CLASSES];
    logic [0:HV_DIMENSION-1]     queryReg;
    logic [0:HV_DIMENSION-1]     bundledQuery;
    logic [LABEL_WIDTH-1:0]      classCnt;
    logic [CHUNK_CNT_WIDTH-1:0]  chunkCnt;
    logic [DISTANCE_WIDTH-1:0]   accReg    [CHANNELS];
    logic [DISTANCE_WIDTH-1:0]   bestDist  [CHANNELS];
    logic [LABEL_WIDTH-1:0]      bestLabel [CHANNELS];
    logic [LABEL_WIDTH-1:0]      labelOut  [CHANNELS];
    logic [DISTANCE_WIDTH-1:0]   distOut   [CHANNELS];

    logic [CHUNK_WIDTH-1:0]      queryChunk [NUM_CHUNKS];
    logic [CHUNK_WIDTH-1:0]      protoChunk [CHANNELS][NUM_CHUNKS];
    logic [CHUNK_WIDTH-1:0]      diffChunk  [CHANNELS];
    logic [POP_WIDTH-1:0]        chunkPop   [CHANNELS];
    logic [DISTANCE_WIDTH-1:0]   sumDist    [CHANNELS];
    logic [DISTANCE_WIDTH-1:0]   nextBestDist  [CHANNELS];
    logic [LABEL_WIDTH-1:0]      nextBestLabel [CHANNELS];

    logic readyOutReg;
    logic amWrReadyReg;
    logic validOutReg;
    logic queryAccept;
    logic writeAccept;
    logic writeInRange;

    // Bitwise majority across modalities: a transposed column per bit position
    // holds that bit of every modality, and the query bit is set when at least
    // half (rounded up) of the column is ones.
    for (genvar b = 0; b < HV_DIMENSION; b++) begin : gen_majority
        logic [MODALITIES-1:0] column;
        for (genvar m = 0; m < MODALITIES; m++) begin : gen_column
            assign column[m] = amIf.HypervectorIn_DI[m*HV_DIMENSION + b];
        end
        assign bundledQuery[b] = ($countones(column) >= ((MODALITIES + 1) / 2));
    end

    // Constant chunk slicing of the query and of the class currently being
    // scored; chunkCnt then picks one slice per cycle.
    for (genvar k = 0; k < NUM_CHUNKS; k++) begin : gen_query_chunk
        assign queryChunk[k] = queryReg[k*CHUNK_WIDTH +: CHUNK_WIDTH];
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : gen_channel
        for (genvar k = 0; k < NUM_CHUNKS; k++) begin : gen_proto_chunk
            assign protoChunk[ch][k] = protoMem[ch][classCnt][k*CHUNK_WIDTH +: CHUNK_WIDTH];
        end

        assign diffChunk[ch] = protoChunk[ch][chunkCnt] ^ queryChunk[chunkCnt];

        hv_chunk_popcount #(
            .CHUNK_WIDTH (CHUNK_WIDTH),
            .POP_WIDTH   (POP_WIDTH)
        ) i_popcount (
            .Chunk_DI (diffChunk[ch]),
            .Count_DO (chunkPop[ch])
        );

        assign amIf.LabelOut_DO[ch*LABEL_WIDTH +: LABEL_WIDTH]          = labelOut[ch];
        assign amIf.DistanceOut_DO[ch*DISTANCE_WIDTH +: DISTANCE_WIDTH] = distOut[ch];
    end

    // Running distance including this cycle's chunk, and the best-so-far it
    // would produce if this is the last chunk of a class. Class 0 always
    // seeds the best; later classes must be strictly closer, so the lowest
    // index keeps a tie.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            sumDist[ch] = accReg[ch] + DISTANCE_WIDTH'(chunkPop[ch]);
            if ((classCnt == '0) || (sumDist[ch] < bestDist[ch])) begin
                nextBestDist[ch]  = sumDist[ch];
                nextBestLabel[ch] = classCnt;
            end else begin
                nextBestDist[ch]  = bestDist[ch];
                nextBestLabel[ch] = bestLabel[ch];
            end
        end
    end

    // Handshake qualifiers. Out-of-range write targets are silently dropped,
    // the comparison is widened so it stays meaningful for any CHANNELS/CLASSES.
    assign queryAccept  = amIf.ValidIn_SI && readyOutReg && (state == IDLE);
    assign writeAccept  = amIf.AmWrEn_SI && amWrReadyReg;
    assign writeInRange = (32'(amIf.AmWrChannel_DI) < 32'(CHANNELS)) &&
                          (32'(amIf.AmWrClass_DI) < 32'(CLASSES));

    assign amIf.ReadyOut_SO  = readyOutReg;
    assign amIf.AmWrReady_SO = amWrReadyReg;
    assign amIf.ValidOut_SO  = validOutReg;

    // Controller and datapath registers. Ready flags are registered so they
    // drop on the same edge that leaves IDLE and rise on the edge that
    // returns to it. A write accepted together with a query lands before the
    // first COMPUTE cycle, so the search already sees it.
    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            state        <= IDLE;
            readyOutReg  <= 1'b0;
            amWrReadyReg <= 1'b0;
            validOutReg  <= 1'b0;
            queryReg     <= '0;
            classCnt     <= '0;
            chunkCnt     <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                accReg[ch]    <= '0;
                bestDist[ch]  <= '0;
                bestLabel[ch] <= '0;
                labelOut[ch]  <= '0;
                distOut[ch]   <= '0;
                for (int c = 0; c < CLASSES; c++) begin
                    protoMem[ch][c] <= '0;
                end
            end
        end else begin
            if (writeAccept && writeInRange) begin
                protoMem[amIf.AmWrChannel_DI][amIf.AmWrClass_DI] <= amIf.AmWrData_DI;
            end

            unique case (state)
                IDLE: begin
                    if (queryAccept) begin
                        queryReg     <= bundledQuery;
                        classCnt     <= '0;
                        chunkCnt     <= '0;
                        for (int ch = 0; ch < CHANNELS; ch++) begin
                            accReg[ch] <= '0;
                        end
                        readyOutReg  <= 1'b0;
                        amWrReadyReg <= 1'b0;
                        state        <= COMPUTE;
                    end else begin
                        readyOutReg  <= 1'b1;
                        amWrReadyReg <= 1'b1;
                    end
                end

                COMPUTE: begin
                    for (int ch = 0; ch < CHANNELS; ch++) begin
                        if (chunkCnt == LAST_CHUNK) begin
                            accReg[ch]    <= '0;
                            bestDist[ch]  <= nextBestDist[ch];
                            bestLabel[ch] <= nextBestLabel[ch];
                        end else begin
                            accReg[ch] <= sumDist[ch];
                        end
                    end
                    if (chunkCnt == LAST_CHUNK) begin
                        chunkCnt <= '0;
                        if (classCnt == LAST_CLASS) begin
                            for (int ch = 0; ch < CHANNELS; ch++) begin
                                labelOut[ch] <= nextBestLabel[ch];
                                distOut[ch]  <= nextBestDist[ch];
                            end
                            validOutReg <= 1'b1;
                            state       <= OUTPUT;
                        end else begin
                            classCnt <= classCnt + 1'b1;
                        end
                    end else begin
                        chunkCnt <= chunkCnt + 1'b1;
                    end
                end

                OUTPUT: begin
                    if (amIf.ReadyIn_SI) begin
                        validOutReg  <= 1'b0;
                        readyOutReg  <= 1'b1;
                        amWrReadyReg <= 1'b1;
                        state        <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_associative_memory_multi.sv
// tb_associative_memory_multi
// Directed bench for associative_memory_multi in the small configuration
// (HV_DIMENSION=16, CHUNK_WIDTH=4, CLASSES=3, CHANNELS=2, MODALITIES=3).
// Hex literals are written bit 0 first, matching the [0:N-1] vector order.
module tb_associative_memory_multi;

    localparam int HV_DIMENSION   = 16;
    localparam int CHUNK_WIDTH    = 4;
    localparam int CLASSES        = 3;
    localparam int CHANNELS       = 2;
    localparam int MODALITIES     = 3;
    localparam int LABEL_WIDTH    = 2;
    localparam int DISTANCE_WIDTH = 5;
    localparam int LATENCY        = 12;
    localparam int WAIT_LIMIT     = 40;

    logic Clk_CI;
    logic Reset_RI;
    int   checkCount;
    int   passCount;
    int   latency;

    associative_memory_multi_if #(
        .HV_DIMENSION (HV_DIMENSION),
        .CLASSES      (CLASSES),
        .CHANNELS     (CHANNELS),
        .MODALITIES   (MODALITIES)
    ) amIf ();

    associative_memory_multi #(
        .HV_DIMENSION (HV_DIMENSION),
        .CLASSES      (CLASSES),
        .CHANNELS     (CHANNELS),
        .MODALITIES   (MODALITIES),
        .CHUNK_WIDTH  (CHUNK_WIDTH)
    ) dut (
        .Clk_CI   (Clk_CI),
        .Reset_RI (Reset_RI),
        .amIf     (amIf)
    );

    // Free-running 10-unit clock.
    initial begin
        Clk_CI = 1'b0;
        forever #5 Clk_CI = ~Clk_CI;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge Clk_CI);
        #1;
    endtask

    // Compares both channels' label and distance against expected values.
    task automatic checkResult(input string tag, input int lab0, input int dist0,
                               input int lab1, input int dist1);
        checkOutput({tag, " ch0 label"}, 32'(amIf.LabelOut_DO[0 +: LABEL_WIDTH]), 32'(lab0));
        checkOutput({tag, " ch0 dist"},  32'(amIf.DistanceOut_DO[0 +: DISTANCE_WIDTH]), 32'(dist0));
        checkOutput({tag, " ch1 label"}, 32'(amIf.LabelOut_DO[LABEL_WIDTH +: LABEL_WIDTH]), 32'(lab1));
        checkOutput({tag, " ch1 dist"},  32'(amIf.DistanceOut_DO[DISTANCE_WIDTH +: DISTANCE_WIDTH]), 32'(dist1));
    endtask

    // Writes one prototype while the memory is idle.
    task automatic writeProto(input int ch, input int cls, input logic [0:15] data);
        amIf.AmWrEn_SI      = 1'b1;
        amIf.AmWrChannel_DI = 1'(ch);
        amIf.AmWrClass_DI   = 2'(cls);
        amIf.AmWrData_DI    = data;
        checkOutput("write ready in idle", 32'(amIf.AmWrReady_SO), 32'd1);
        tick();
        amIf.AmWrEn_SI = 1'b0;
    endtask

    // Presents one query, completes the handshake and waits (bounded) for
    // the result; optionally holds a prototype write strobe during COMPUTE.
    task automatic applyStimulus(input logic [0:15] m0, input logic [0:15] m1,
                                 input logic [0:15] m2, input bit writeDuringCompute,
                                 output int cycles);
        amIf.HypervectorIn_DI = {m0, m1, m2};
        amIf.ValidIn_SI       = 1'b1;
        checkOutput("query ready", 32'(amIf.ReadyOut_SO), 32'd1);
        tick();
        amIf.ValidIn_SI = 1'b0;
        if (writeDuringCompute) begin
            amIf.AmWrEn_SI      = 1'b1;
            amIf.AmWrChannel_DI = 1'd1;
            amIf.AmWrClass_DI   = 2'd1;
            amIf.AmWrData_DI    = 16'hFFFF;
        end
        cycles = 0;
        while (!amIf.ValidOut_SO && cycles < WAIT_LIMIT) begin
            if (writeDuringCompute && cycles == 1) begin
                checkOutput("write ready in compute", 32'(amIf.AmWrReady_SO), 32'd0);
            end
            tick();
            cycles++;
        end
        amIf.AmWrEn_SI = 1'b0;
    endtask

    // Hands the result downstream and checks the return to IDLE.
    task automatic releaseResult();
        amIf.ReadyIn_SI = 1'b1;
        tick();
        amIf.ReadyIn_SI = 1'b0;
        checkOutput("valid after release", 32'(amIf.ValidOut_SO), 32'd0);
        checkOutput("ready after release", 32'(amIf.ReadyOut_SO), 32'd1);
    endtask

    initial begin
        checkCount            = 0;
        passCount             = 0;
        Reset_RI              = 1'b1;
        amIf.ValidIn_SI       = 1'b0;
        amIf.ReadyIn_SI       = 1'b0;
        amIf.HypervectorIn_DI = '0;
        amIf.AmWrEn_SI        = 1'b0;
        amIf.AmWrChannel_DI   = '0;
        amIf.AmWrClass_DI     = '0;
        amIf.AmWrData_DI      = '0;

        // Reset state.
        tick();
        tick();
        checkOutput("reset valid", 32'(amIf.ValidOut_SO), 32'd0);
        checkOutput("reset ready", 32'(amIf.ReadyOut_SO), 32'd0);
        checkResult("reset", 0, 0, 0, 0);
        Reset_RI = 1'b0;
        tick();
        checkOutput("ready after reset", 32'(amIf.ReadyOut_SO), 32'd1);
        checkOutput("wr ready after reset", 32'(amIf.AmWrReady_SO), 32'd1);

        // Tie-break: c0 and c2 both at distance 4, lowest index wins.
        writeProto(0, 0, 16'h0000);
        writeProto(0, 1, 16'hFFFF);
        writeProto(0, 2, 16'h00FF);
        applyStimulus(16'h00F0, 16'h00F0, 16'h00F0, 1'b0, latency);
        checkOutput("tiebreak latency", 32'(latency), 32'(LATENCY));
        checkResult("tiebreak", 0, 4, 0, 4);
        releaseResult();

        // Majority bundling gives query 0x0F00; ch1 matches class 1 exactly.
        writeProto(1, 0, 16'hF000);
        writeProto(1, 1, 16'h0F00);
        writeProto(1, 2, 16'h00F0);
        applyStimulus(16'hFF00, 16'h0FF0, 16'h000F, 1'b0, latency);
        checkOutput("majority latency", 32'(latency), 32'(LATENCY));
        checkResult("majority", 0, 4, 1, 0);
        releaseResult();

        // Backpressure: result held, ready low, a query pulse is ignored.
        applyStimulus(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, latency);
        checkResult("ones query", 1, 0, 0, 12);
        for (int i = 0; i < 5; i++) begin
            amIf.HypervectorIn_DI = '0;
            amIf.ValidIn_SI       = (i == 2);
            tick();
            amIf.ValidIn_SI = 1'b0;
            checkOutput("hold valid", 32'(amIf.ValidOut_SO), 32'd1);
            checkOutput("hold ready", 32'(amIf.ReadyOut_SO), 32'd0);
            checkResult("hold", 1, 0, 0, 12);
        end
        releaseResult();
        tick();
        tick();
        checkOutput("no stray query", 32'(amIf.ReadyOut_SO), 32'd1);
        checkResult("kept in idle", 1, 0, 0, 12);

        // A write strobe during COMPUTE must have no effect on the result.
        applyStimulus(16'hFF00, 16'h0FF0, 16'h000F, 1'b1, latency);
        checkResult("write in compute", 0, 4, 1, 0);
        releaseResult();

        // Out-of-range class write is dropped; prototypes stay as before.
        writeProto(0, 3, 16'hFFFF);
        applyStimulus(16'hFF00, 16'h0FF0, 16'h000F, 1'b0, latency);
        checkResult("dropped write a", 0, 4, 1, 0);
        releaseResult();
        applyStimulus(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, latency);
        checkResult("dropped write b", 1, 0, 0, 12);
        releaseResult();

        // Reset during COMPUTE cycle 6 discards the search and all state.
        amIf.HypervectorIn_DI = {16'hFF00, 16'h0FF0, 16'h000F};
        amIf.ValidIn_SI       = 1'b1;
        tick();
        amIf.ValidIn_SI = 1'b0;
        repeat (5) tick();
        Reset_RI = 1'b1;
        tick();
        Reset_RI = 1'b0;
        checkOutput("midreset valid", 32'(amIf.ValidOut_SO), 32'd0);
        checkOutput("midreset ready", 32'(amIf.ReadyOut_SO), 32'd0);
        checkResult("midreset", 0, 0, 0, 0);
        tick();
        applyStimulus(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, latency);
        checkOutput("post reset latency", 32'(latency), 32'(LATENCY));
        checkResult("post reset", 0, 16, 0, 16);
        releaseResult();

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
